// File: rtl/wb_modport_pkg.sv
// Shared types, widths and helpers for the 32-bit core to 128-bit Wishbone bridge.
package wb_modport_pkg;
  localparam int unsigned WB_DW   = 128;
  localparam int unsigned CORE_DW = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned SEL_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero byte-enable from the core means a full-word access.
  function automatic logic [3:0] eff_be(input logic [3:0] be);
    logic [3:0] res;
    if (be == 4'h0) begin
      res = 4'hF;
    end else begin
      res = be;
    end
    return res;
  endfunction
endpackage

// File: rtl/wb_lane_steer.sv
// Combinational lane steering: byte selects and replicated write data out, addressed read lane in.
module wb_lane_steer
  import wb_modport_pkg::*;
(
  input  logic [3:0]         be,
  input  logic [1:0]         lane,
  input  logic [CORE_DW-1:0] wdat,
  input  logic [WB_DW-1:0]   wb_dat,
  output logic [SEL_W-1:0]   sel,
  output logic [WB_DW-1:0]   dat,
  output logic [CORE_DW-1:0] rdat
);
  // Place the enables in the addressed lane, replicate write data, pick the read lane.
  always_comb begin
    sel  = {12'h000, eff_be(be)} << {lane, 2'b00};
    dat  = {LANES{wdat}};
    rdat = wb_dat[{lane, 5'b00000} +: CORE_DW];
  end
endmodule

// File: rtl/wb_modport_bridge.sv
// Single-outstanding bridge from a 32-bit core port onto a 128-bit Wishbone bus with timeout.
// Optional feature: define WB_ERR_STICKY_EN to latch errors on o_core_err_sticky until reset.
module wb_modport_bridge
  import wb_modport_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_system_rdy,
  input  logic               i_core_req,
  input  logic               i_core_we,
  input  logic [31:0]        i_core_adr,
  input  logic [3:0]         i_core_be,
  input  logic [CORE_DW-1:0] i_core_wdat,
  output logic [CORE_DW-1:0] o_core_rdat,
  output logic               o_core_done,
  output logic               o_core_err,
  output logic               o_core_err_sticky,
  output logic [31:0]        o_wb_adr,
  output logic [SEL_W-1:0]   o_wb_sel,
  output logic               o_wb_we,
  output logic [WB_DW-1:0]   o_wb_dat,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  input  logic [WB_DW-1:0]   i_wb_dat,
  input  logic               i_wb_ack,
  input  logic               i_wb_err
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t             state_r;
  logic [1:0]         lane_r;
  logic [7:0]         cnt_r;
  logic [1:0]         lane_sel_s;
  logic [SEL_W-1:0]   sel_s;
  logic [WB_DW-1:0]   dat_s;
  logic [CORE_DW-1:0] rdat_s;
  logic               unused_adr_s;

  assign unused_adr_s = ^i_core_adr[1:0];

  // Steer from the live address while idle, from the captured lane once the cycle is out.
  always_comb begin
    if (state_r == IDLE) begin
      lane_sel_s = i_core_adr[3:2];
    end else begin
      lane_sel_s = lane_r;
    end
  end

  wb_lane_steer u_steer (
    .be     (i_core_be),
    .lane   (lane_sel_s),
    .wdat   (i_core_wdat),
    .wb_dat (i_wb_dat),
    .sel    (sel_s),
    .dat    (dat_s),
    .rdat   (rdat_s)
  );

  // Transfer FSM; every bus and core output is registered here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      lane_r      <= 2'd0;
      cnt_r       <= 8'd0;
      o_core_rdat <= '0;
      o_core_done <= 1'b0;
      o_core_err  <= 1'b0;
      o_wb_adr    <= 32'h0;
      o_wb_sel    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_dat    <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_core_req && i_system_rdy) begin
            o_wb_adr <= {i_core_adr[31:4], 4'h0};
            o_wb_sel <= sel_s;
            o_wb_we  <= i_core_we;
            o_wb_dat <= dat_s;
            lane_r   <= i_core_adr[3:2];
            cnt_r    <= 8'd0;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            state_r  <= BUS;
          end
        end
        BUS: begin
          // A slave error outranks a simultaneous ack; silence until TO_LAST is a timeout error.
          if (i_wb_ack || i_wb_err || (cnt_r == TO_LAST)) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_core_done <= 1'b1;
            o_core_err  <= i_wb_err || !i_wb_ack;
            if (i_wb_ack && !i_wb_err && !o_wb_we) begin
              o_core_rdat <= rdat_s;
            end else begin
              o_core_rdat <= '0;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          o_core_done <= 1'b0;
          o_core_err  <= 1'b0;
          o_core_rdat <= '0;
          state_r     <= IDLE;
        end
        default: begin
          o_wb_cyc    <= 1'b0;
          o_wb_stb    <= 1'b0;
          o_core_done <= 1'b0;
          o_core_err  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ERR_STICKY_EN
  logic err_sticky_r;

  // Error flag that survives until reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_sticky_r <= 1'b0;
    end else if (o_core_err) begin
      err_sticky_r <= 1'b1;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

  assign o_core_err_sticky = err_sticky_r;
`else
  assign o_core_err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_wb_modport_bridge.sv
// Self-checking bench for wb_modport_bridge: directed table, corner sequences, randomized model check.
module tb_wb_modport_bridge;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rdy;
  logic         req;
  logic         we;
  logic [31:0]  adr;
  logic [3:0]   be;
  logic [31:0]  wdat;
  logic [31:0]  rdat;
  logic         done;
  logic         err;
  logic         sticky;
  logic [31:0]  wb_adr;
  logic [15:0]  wb_sel;
  logic         wb_we;
  logic [127:0] wb_dat_o;
  logic         wb_cyc;
  logic         wb_stb;
  logic [127:0] wb_dat_i;
  logic         wb_ack;
  logic         wb_err;

  int   checks = 0;
  int   errors = 0;
  logic seen_err = 1'b0;

  always #5 clk = ~clk;

  wb_modport_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_system_rdy      (rdy),
    .i_core_req        (req),
    .i_core_we         (we),
    .i_core_adr        (adr),
    .i_core_be         (be),
    .i_core_wdat       (wdat),
    .o_core_rdat       (rdat),
    .o_core_done       (done),
    .o_core_err        (err),
    .o_core_err_sticky (sticky),
    .o_wb_adr          (wb_adr),
    .o_wb_sel          (wb_sel),
    .o_wb_we           (wb_we),
    .o_wb_dat          (wb_dat_o),
    .o_wb_cyc          (wb_cyc),
    .o_wb_stb          (wb_stb),
    .i_wb_dat          (wb_dat_i),
    .i_wb_ack          (wb_ack),
    .i_wb_err          (wb_err)
  );

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [3:0]   be;
    logic [31:0]  wdat;
    int           dly;
    logic         ack;
    logic         err;
    logic [127:0] rd;
    logic [31:0]  e_adr;
    logic [15:0]  e_sel;
    logic         e_err;
    logic [31:0]  e_rdat;
    int           e_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_sticky();
`ifdef WB_ERR_STICKY_EN
    return seen_err;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: plain arithmetic on the lane number.
  function automatic logic [15:0] m_sel(input logic [31:0] a, input logic [3:0] b);
    int unsigned lane = (a / 4) % 4;
    int unsigned eb   = (b == 4'h0) ? 15 : int'(b);
    return 16'(eb * (1 << (4 * lane)));
  endfunction

  function automatic logic [31:0] m_lane(input logic [31:0] a, input logic [127:0] d);
    int unsigned  lane = (a / 4) % 4;
    logic [127:0] t;
    t = d >> (32 * lane);
    return t[31:0];
  endfunction

  // One complete transfer, called and returning on a falling edge.
  task automatic xfer(input vec_t v);
    int lat;
    lat      = 0;
    req      = 1'b1;
    we       = v.we;
    adr      = v.adr;
    be       = v.be;
    wdat     = v.wdat;
    rdy      = 1'b1;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = v.rd;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("cyc", 128'(wb_cyc), 128'(1'b1));
        chk("stb", 128'(wb_stb), 128'(1'b1));
        chk("wb_adr", 128'(wb_adr), 128'(v.e_adr));
        chk("wb_sel", 128'(wb_sel), 128'(v.e_sel));
        chk("wb_we", 128'(wb_we), 128'(v.we));
        chk("wb_dat", wb_dat_o, {4{v.wdat}});
        rdy = 1'($urandom_range(0, 1));
      end
      if (done) begin
        lat = c;
        chk("core_err", 128'(err), 128'(v.e_err));
        chk("core_rdat", 128'(rdat), 128'(v.e_rdat));
        chk("cyc_drop", 128'(wb_cyc), 128'(1'b0));
        req = 1'b0;
      end
      wb_ack = (c == v.dly + 1) ? v.ack : 1'b0;
      wb_err = (c == v.dly + 1) ? v.err : 1'b0;
    end
    req = 1'b0;
    chk("latency", 128'(lat), 128'(v.e_lat));
    if (v.e_err) seen_err = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(1'b0));
    chk("sticky", 128'(sticky), 128'(exp_sticky()));
  endtask

  initial begin
    int   hit;
    vec_t v;
    vecs[0] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0, 0, 1'b1, 1'b0,
                {32'hD, 32'hC, 32'hB, 32'hA}, 32'h0, 16'h0F00, 1'b0, 32'h0000_000C, 2};
    vecs[1] = '{1'b1, 32'h0000_0014, 4'b0011, 32'h1234_5678, 1, 1'b1, 1'b0,
                128'h0, 32'h10, 16'h0030, 1'b0, 32'h0, 3};
    vecs[2] = '{1'b0, 32'h0000_010C, 4'h0, 32'h0, 2, 1'b1, 1'b0,
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                32'h100, 16'hF000, 1'b0, 32'h4444_4444, 4};
    vecs[3] = '{1'b0, 32'h0000_0004, 4'b1000, 32'h0, 0, 1'b1, 1'b1,
                {4{32'hCAFE_F00D}}, 32'h0, 16'h0080, 1'b1, 32'h0, 2};
    vecs[4] = '{1'b0, 32'h0000_0020, 4'b0001, 32'h0, 0, 1'b0, 1'b0,
                {4{32'h5A5A_5A5A}}, 32'h20, 16'h0001, 1'b1, 32'h0, TO + 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hDEAD_BEEF, 1, 1'b0, 1'b1,
                128'h0, 32'hFFFF_FFF0, 16'hC000, 1'b1, 32'h0, 3};

    rst_n = 1'b0; rdy = 1'b0; req = 1'b0; we = 1'b0; adr = 32'h0; be = 4'h0;
    wdat = 32'h0; wb_dat_i = 128'h0; wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 128'(wb_cyc), 128'(1'b0));
    chk("rst_stb", 128'(wb_stb), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_sticky", 128'(sticky), 128'(1'b0));
    chk("rst_bus", {wb_adr, wb_sel, wb_we, rdat, 47'h0}, 128'h0);
    chk("rst_wbdat", wb_dat_o, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) xfer(vecs[i]);

    // Request held while the system is not ready must not start a cycle.
    req = 1'b1; we = 1'b0; adr = 32'h40; be = 4'hF; rdy = 1'b0;
    wb_dat_i = {32'h4, 32'h3, 32'h2, 32'h1};
    hit = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wb_cyc) hit++;
    end
    chk("rdy_block", 128'(hit), 128'(0));
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_accept", 128'(wb_cyc), 128'(1'b1));
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0; req = 1'b0;
    chk("rdy_done", 128'(done), 128'(1'b1));
    chk("rdy_rdat", 128'(rdat), 128'(32'h1));
    @(negedge clk);

    // Reset while a cycle is outstanding: bus drops, no completion pulse.
    req = 1'b1; we = 1'b0; adr = 32'h8; be = 4'hF; rdy = 1'b1;
    @(negedge clk);
    chk("midbus_cyc", 128'(wb_cyc), 128'(1'b1));
    rst_n = 1'b0; req = 1'b0;
    hit = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) hit++;
      if (c == 0) chk("midbus_drop", 128'(wb_cyc), 128'(1'b0));
      if (c == 1) rst_n = 1'b1;
    end
    chk("midbus_no_done", 128'(hit), 128'(0));
    seen_err = 1'b0;
    chk("midbus_sticky", 128'(sticky), 128'(1'b0));

    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      v.we   = 1'($urandom_range(0, 1));
      v.adr  = $urandom;
      v.be   = 4'($urandom_range(0, 15));
      v.wdat = $urandom;
      v.dly  = $urandom_range(0, 2);
      v.rd   = {$urandom, $urandom, $urandom, $urandom};
      kind   = $urandom_range(0, 7);
      v.ack  = (kind != 0) && (kind != 2);
      v.err  = (kind == 0) || (kind == 1);
      v.e_adr  = (v.adr / 16) * 16;
      v.e_sel  = m_sel(v.adr, v.be);
      v.e_err  = v.err || !v.ack;
      v.e_rdat = (!v.e_err && !v.we) ? m_lane(v.adr, v.rd) : 32'h0;
      v.e_lat  = (v.ack || v.err) ? v.dly + 2 : TO + 1;
      xfer(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
